sfm_tcdm_responder: RTL

//   Single-port TCDM memory responder: the slave end of the HCI core request/response

---
 rtl/sfm_tcdm_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sfm_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : sfm_tcdm_responder
// Brief    : Single-port TCDM slave with word scratchpad, optional grant
//            throttling and fixed-latency in-order response pipeline.
// Revision : 1.0
// ============================================================================

module sfm_tcdm_responder #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned STALL_EVERY = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   add_i,
    input  logic                    wen_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    r_valid_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic                    err_o,
    output logic [31:0]             n_rd_o,
    output logic [31:0]             n_wr_o
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
        ADDR_WIDTH'((64'd1 << (OFF_W + IDX_W)) - 64'd1);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic                  r_vld [LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [LATENCY];
    logic                  r_err;
    logic [31:0]           r_n_rd;
    logic [31:0]           r_n_wr;

    logic                  w_stall;
    logic                  w_accept;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_oor;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_active;

    generate
        if (STALL_EVERY >= 2) begin : g_throttle
            localparam int unsigned CNT_W = $clog2(STALL_EVERY);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(STALL_EVERY - 1);
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk_i) begin
                if (!rst_ni || clear_i) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_stall = (r_cnt == LAST);
        end else begin : g_no_throttle
            assign w_stall = 1'b0;
        end
    endgenerate

    assign gnt_o    = req_i && !w_stall;
    assign w_active = rst_ni && !clear_i;
    assign w_accept = req_i && gnt_o && w_active;
    assign w_rd     = w_accept && wen_i;
    assign w_wr     = w_accept && !wen_i;

    // Any address bit above the word-index field makes the access out of range.
    assign w_oor      = |(add_i & ~LOW_MASK);
    assign w_idx      = add_i[OFF_W +: IDX_W];
    assign w_rsp_data = (w_rd && !w_oor) ? r_mem[w_idx] : '0;

    always_ff @(posedge clk_i) begin
        if (w_wr && !w_oor) begin
            for (int k = 0; k < int'(BYTES); k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][k*8 +: 8] <= data_i[k*8 +: 8];
                end
            end
        end
    end

    // Each stage's data only moves with a valid token, so the last stage
    // holds the most recent response between pulses.
    always_ff @(posedge clk_i) begin
        if (!w_active) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
            end
            r_err  <= 1'b0;
            r_n_rd <= '0;
            r_n_wr <= '0;
        end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_dat[0] <= w_rsp_data;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
            if (w_accept && w_oor) begin
                r_err <= 1'b1;
            end
            if (w_rd) begin
                r_n_rd <= r_n_rd + 32'd1;
            end
            if (w_wr) begin
                r_n_wr <= r_n_wr + 32'd1;
            end
        end
    end

    assign r_valid_o = r_vld[LATENCY-1];
    assign r_data_o  = r_dat[LATENCY-1];
    assign err_o     = r_err;
    assign n_rd_o    = r_n_rd;
    assign n_wr_o    = r_n_wr;

endmodule

`default_nettype wire
